// File: rtl/countdown_timer_ctrl.sv
// Programmable down-counter sequencer with pause/resume, abort and auto-reload.
// Emits a registered one-cycle done pulse when the count reaches its terminal value.
module countdown_timer_ctrl #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic [WIDTH-1:0] reload_q, reload_nxt;
  logic             done_q, done_nxt;

  // Floors at zero so the counter can never wrap to all-ones.
  function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
    if (v == '0) return '0;
    return v - WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    done_nxt   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start && (load_val != '0)) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = PAUSE;
          end else if (count_q > WIDTH'(1)) begin
            count_nxt = dec_sat(count_q);
          end else if (count_q == WIDTH'(1)) begin
            done_nxt = 1'b1;
            if (auto_reload) begin
              count_nxt = reload_q;
            end else begin
              count_nxt = '0;
              state_nxt = DONE;
            end
          end else begin
            // Zero while running cannot arise from a legal load; park in DONE.
            count_nxt = '0;
            state_nxt = DONE;
          end
        end
        PAUSE: begin
          if (!pause) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Table-driven bench for countdown_timer_ctrl with a scoreboard queue of
// expected post-edge outputs, plus hand-written async-reset and full-range sequences.
module tb_countdown_timer_ctrl;

  localparam int WIDTH = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, pause, abort, auto_reload;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy, done;

  countdown_timer_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .auto_reload(auto_reload), .load_val(load_val),
    .count(count), .state(state), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             st;
    logic             pa;
    logic             ab;
    logic             ar;
    logic [WIDTH-1:0] ld;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       sta;
    logic             dn;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] cnt;
    logic [1:0]       sta;
    logic             dn;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic s, input logic p, input logic a, input logic r,
                              input int ld, input int c, input int st, input logic d);
    vec_t v;
    v.st = s; v.pa = p; v.ab = a; v.ar = r;
    v.ld = WIDTH'(ld); v.cnt = WIDTH'(c); v.sta = 2'(st); v.dn = d;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      cmp({tag, "_scoreboard_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "_count"}, int'(count), int'(e.cnt));
    cmp({tag, "_state"}, int'(state), int'(e.sta));
    cmp({tag, "_busy"},  int'(busy),  int'((e.sta == 2'b01) || (e.sta == 2'b10)));
    cmp({tag, "_done"},  int'(done),  int'(e.dn));
  endtask

  task automatic step(input logic s, input logic p, input logic a, input logic r,
                      input logic [WIDTH-1:0] ld, input logic [WIDTH-1:0] c,
                      input logic [1:0] st, input logic d, input string tag);
    exp_t e;
    start = s; pause = p; abort = a; auto_reload = r; load_val = ld;
    e.cnt = c; e.sta = st; e.dn = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    // Basic countdown of 5, DONE sticky
    tbl.push_back(mk(1, 0, 0, 0, 5, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 0));
    // Abort to IDLE, then zero load is ignored
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    // Pause for three cycles at count 3, then resume
    tbl.push_back(mk(1, 0, 0, 0, 4, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 2, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 3, 2, 0));
    tbl.push_back(mk(1, 1, 0, 0, 9, 3, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 1));
    // Restart from DONE; start while running is ignored
    tbl.push_back(mk(1, 0, 0, 0, 6, 6, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9, 5, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0));
    // Abort together with pause at count 7
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 8, 8, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Auto-reload of 3; load_val changes while busy have no effect
    tbl.push_back(mk(1, 0, 0, 1, 3, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 7, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 3, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 7, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7, 0, 3, 1));
    // Abort and start together in DONE: abort wins
    tbl.push_back(mk(1, 0, 1, 0, 5, 0, 0, 0));

    rst = 1'b1;
    start = 1'b0; pause = 1'b0; abort = 1'b0; auto_reload = 1'b0; load_val = '0;
    #12;
    cmp("reset_count", int'(count), 0);
    cmp("reset_state", int'(state), 0);
    cmp("reset_busy",  int'(busy),  0);
    cmp("reset_done",  int'(done),  0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].pa, tbl[i].ab, tbl[i].ar, tbl[i].ld,
           tbl[i].cnt, tbl[i].sta, tbl[i].dn, $sformatf("vec%0d", i));
    end

    // Async reset between edges while counting
    step(1, 0, 0, 0, 5'd10, 5'd10, 2'b01, 1'b0, "rst_pre0");
    step(0, 0, 0, 0, 5'd0,  5'd9,  2'b01, 1'b0, "rst_pre1");
    #2 rst = 1'b1;
    #1;
    cmp("async_rst_count", int'(count), 0);
    cmp("async_rst_state", int'(state), 0);
    cmp("async_rst_busy",  int'(busy),  0);
    @(posedge clk);
    #1;
    cmp("held_rst_count", int'(count), 0);
    cmp("held_rst_done",  int'(done),  0);
    rst = 1'b0;

    // Full-range load: done exactly 31 cycles after the start edge
    step(1, 0, 0, 0, 5'd31, 5'd31, 2'b01, 1'b0, "max_load");
    for (int i = 1; i <= 31; i++) begin
      step(0, 0, 0, 0, 5'd0, WIDTH'(31 - i), (i == 31) ? 2'b11 : 2'b01,
           (i == 31), $sformatf("max_cyc%0d", i));
    end
    step(0, 0, 0, 0, 5'd0, 5'd0, 2'b11, 1'b0, "max_after");

    cmp("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
